// File: rtl/tx_rc_pkg.sv
// Shared widths, beat phase encoding and lane formatting for the TX rate converter.
package tx_rc_pkg;

  localparam int unsigned NSAMP  = 16;
  localparam int unsigned SAMP_W = 12;
  localparam int unsigned LANE_W = 16;
  localparam int unsigned BEAT_W = NSAMP / 2 * LANE_W;

  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } phase_t;

  function automatic logic [LANE_W-1:0] lane_fmt(input logic [SAMP_W-1:0] samp);
    lane_fmt = {samp, {(LANE_W-SAMP_W){1'b0}}};
  endfunction

endpackage

// File: rtl/tx_lane_format.sv
// Combinational MSB-aligned formatting of NSAMP samples into NSAMP DAC lanes.
module tx_lane_format #(
  parameter int unsigned NSAMP  = tx_rc_pkg::NSAMP,
  parameter int unsigned SAMP_W = tx_rc_pkg::SAMP_W,
  parameter int unsigned LANE_W = tx_rc_pkg::LANE_W
) (
  input  logic [NSAMP*SAMP_W-1:0] i_samples,
  output logic [NSAMP*LANE_W-1:0] o_lanes
);
  import tx_rc_pkg::*;

  generate
    if (SAMP_W == tx_rc_pkg::SAMP_W && LANE_W == tx_rc_pkg::LANE_W) begin : g_pkg_fmt
      always_comb begin
        o_lanes = '0;
        for (int unsigned k = 0; k < NSAMP; k++) begin
          o_lanes[LANE_W*k +: LANE_W] = lane_fmt(i_samples[SAMP_W*k +: SAMP_W]);
        end
      end
    end else begin : g_gen_fmt
      always_comb begin
        o_lanes = '0;
        for (int unsigned k = 0; k < NSAMP; k++) begin
          o_lanes[LANE_W*k +: LANE_W] = LANE_W'(i_samples[SAMP_W*k +: SAMP_W]) << (LANE_W - SAMP_W);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/tx_rate_convert.sv
// TX gearbox: one NSAMP-sample I/Q word in, two half-word DAC beats out.
// Optional TXRC_ZERO_FILL_EN keeps m_valid high while enabled, filling starved cycles with zeros.
module tx_rate_convert #(
  parameter int unsigned NSAMP  = tx_rc_pkg::NSAMP,
  parameter int unsigned SAMP_W = tx_rc_pkg::SAMP_W,
  parameter int unsigned LANE_W = tx_rc_pkg::LANE_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [NSAMP*SAMP_W-1:0]   s_data_i,
  input  logic [NSAMP*SAMP_W-1:0]   s_data_q,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [NSAMP/2*LANE_W-1:0] m_data_i,
  output logic [NSAMP/2*LANE_W-1:0] m_data_q,
  output logic                      m_last,
  output logic [15:0]               underrun_cnt
);
  import tx_rc_pkg::*;

  localparam int unsigned BW = NSAMP / 2 * LANE_W;

  logic [NSAMP*LANE_W-1:0] w_fmt_i;
  logic [NSAMP*LANE_W-1:0] w_fmt_q;
  logic [NSAMP*LANE_W-1:0] r_buf_i;
  logic [NSAMP*LANE_W-1:0] r_buf_q;
  logic                    r_buf_valid;
  logic                    w_buf_valid_nxt;
  phase_t                  r_phase;
  phase_t                  w_phase_nxt;
  logic                    w_accept;
  logic                    w_beat_done;
  logic                    w_starved;
  logic [15:0]             r_underrun;

  tx_lane_format #(.NSAMP(NSAMP), .SAMP_W(SAMP_W), .LANE_W(LANE_W)) u_fmt_i (
    .i_samples (s_data_i),
    .o_lanes   (w_fmt_i)
  );

  tx_lane_format #(.NSAMP(NSAMP), .SAMP_W(SAMP_W), .LANE_W(LANE_W)) u_fmt_q (
    .i_samples (s_data_q),
    .o_lanes   (w_fmt_q)
  );

  // A new word may land in the same cycle the upper beat is taken.
  assign s_ready     = en & ~rst & (~r_buf_valid | ((r_phase == PH_HI) & m_ready));
  assign w_accept    = s_valid & s_ready;
  assign w_beat_done = r_buf_valid & m_ready;
  assign w_starved   = en & m_ready & ~r_buf_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_valid <= 1'b0;
      r_phase     <= PH_LO;
    end else begin
      r_buf_valid <= w_buf_valid_nxt;
      r_phase     <= w_phase_nxt;
    end
  end

  always_comb begin
    w_buf_valid_nxt = r_buf_valid;
    w_phase_nxt     = r_phase;
    if (!en) begin
      w_buf_valid_nxt = 1'b0;
      w_phase_nxt     = PH_LO;
    end else if (w_accept) begin
      w_buf_valid_nxt = 1'b1;
      w_phase_nxt     = PH_LO;
    end else if (w_beat_done) begin
      case (r_phase)
        PH_LO: w_phase_nxt = PH_HI;
        PH_HI: begin
          w_buf_valid_nxt = 1'b0;
          w_phase_nxt     = PH_LO;
        end
        default: w_phase_nxt = PH_LO;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_i <= '0;
      r_buf_q <= '0;
    end else if (w_accept) begin
      r_buf_i <= w_fmt_i;
      r_buf_q <= w_fmt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_underrun <= '0;
    end else if (w_starved && (r_underrun != '1)) begin
      r_underrun <= r_underrun + 16'd1;
    end
  end

  always_comb begin
    m_data_i = '0;
    m_data_q = '0;
    m_last   = 1'b0;
    if (r_buf_valid) begin
      m_last = (r_phase == PH_HI);
      if (r_phase == PH_HI) begin
        m_data_i = r_buf_i[BW +: BW];
        m_data_q = r_buf_q[BW +: BW];
      end else begin
        m_data_i = r_buf_i[0 +: BW];
        m_data_q = r_buf_q[0 +: BW];
      end
    end
  end

`ifdef TXRC_ZERO_FILL_EN
  assign m_valid = r_buf_valid | (en & ~rst);
`else
  assign m_valid = r_buf_valid;
`endif

  assign underrun_cnt = r_underrun;

endmodule

// File: doc/tx_rate_convert.md
Name: tx_rate_convert

Overview:
- Transmit-side gearbox: accepts one word of 16 parallel 12-bit I/Q sample pairs per transfer and emits it to the DAC data converter as two 128-bit I and two 128-bit Q beats.
- Sits between the baseband TX datapath and the DAC interface in the clk domain, which runs at twice the word rate.
- Lane format is the inverse of the RX unpack: each sample is MSB-aligned in a 16-bit lane with 4 zero LSBs.

Parameters:
- NSAMP, 16, samples per input word (even).
- SAMP_W, 12, bits per sample.
- LANE_W, 16, bits per DAC lane (>= SAMP_W).

Ports:
- clk  in  1  converter-rate clock (DAC fabric clock).
- rst  in  1  synchronous active-high reset.
- en  in  1  stream enable; 0 flushes the block.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid & s_ready.
- s_data_i  in  NSAMP*SAMP_W  I samples; sample k at [SAMP_W*k +: SAMP_W], k=0 oldest.
- s_data_q  in  NSAMP*SAMP_W  Q samples, same packing.
- m_valid  out  1  DAC beat valid.
- m_ready  in  1  DAC accepts beat.
- m_data_i  out  NSAMP/2*LANE_W  I beat (128 bits).
- m_data_q  out  NSAMP/2*LANE_W  Q beat.
- m_last  out  1  high on the second (upper) beat of a word.
- underrun_cnt  out  16  saturating count of starved DAC cycles.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: s_ready=0, m_valid=0, m_last=0, m_data_i/q=0, underrun_cnt=0, holding buffer empty, phase=0.
- Capture: on an accepted input, format every sample to {sample, (LANE_W-SAMP_W)'b0} and store the full word in a holding register. Set buf_valid=1 and phase=0.
- Beat mapping:
  - phase 0 drives lanes 0..NSAMP/2-1 (samples 0..7), lane j at bits [LANE_W*j +: LANE_W].
  - phase 1 drives lanes NSAMP/2..NSAMP-1.
  - m_last = phase.
- Outputs:
  - m_valid = buf_valid.
  - m_data is a mux of the holding register by phase; zero when buf_valid=0.
- Latency: word accepted in cycle N gives beat 0 on m_ in cycle N+1 and beat 1 no earlier than N+2.
- Phase advance: on m_valid & m_ready:
  - phase 0 -> 1.
  - phase 1 -> buffer empties, unless a new word is accepted in the same cycle.
- s_ready = en & (!buf_valid | (phase & m_ready)). This allows back-to-back words with no bubble: sustained rate is one word per 2 cycles.
- Simultaneous last-beat handoff and new-word accept: new word loads, buf_valid stays 1, phase=0.
- m_ready low: hold beat and phase; no data is dropped or duplicated.
- Underrun: en=1 & m_ready=1 & buf_valid=0 increments underrun_cnt, saturating at 16'hFFFF. The count clears only on rst.
- en=0:
  - s_ready=0.
  - Holding buffer is discarded at the next clk edge (buf_valid=0, phase=0).
  - underrun_cnt holds.
- rst mid-word: discards everything; the first word accepted after reset starts at phase 0.

Optional Feature:
- Macro: TXRC_ZERO_FILL_EN.
- Defined:
  - While en=1, m_valid is forced to 1 every cycle.
  - Starved cycles output all-zero beats with m_last=0; each zero beat counts as an underrun.
  - Gives a continuous stream for DAC IPs without backpressure tolerance.
- Undefined: m_valid = buf_valid as above.

Decomposition:
- Shared package tx_rc_pkg:
  - NSAMP, SAMP_W, LANE_W defaults and the derived BEAT_W = NSAMP/2*LANE_W.
  - Function lane_fmt(sample) returning the MSB-aligned lane.
- One natural sub-module, tx_lane_format: combinational conversion of NSAMP samples to an NSAMP*LANE_W packed word, instantiated once for I and once for Q.

Test Plan:
- Reset then en=1, s_valid=1, sample k of I = 12'h100+k, Q = 12'hF00+k, m_ready=1:
  - Cycle after accept: m_data_i lane0=16'h1000, lane7=16'h1070, m_last=0.
  - Next cycle: lane0=16'h1080, lane7=16'h10F0, m_last=1.
- Continuous s_valid with m_ready=1 for 20 words: s_ready toggles 1/0, with exactly 40 beats, no gaps, in order, underrun_cnt=0.
- m_ready held 0 for 5 cycles during phase 1: beat stable, s_ready=0, and the beat is delivered once when m_ready returns.
- en=1, m_ready=1, no s_valid for 7 cycles: underrun_cnt=7. With TXRC_ZERO_FILL_EN, m_valid=1 and m_data=0 throughout.
- en dropped after beat 0 of a word: next cycle m_valid=0, and that word's beat 1 is never emitted. On re-enable, a new word starts at phase 0.
- rst asserted with buffer full at phase 1: next cycle all outputs are at reset values and underrun_cnt=0.
